// File: rtl/brq_pkg.sv
// Shared definitions for the Buraq-mini instruction fetch unit:
// fetch FSM state encoding, decode next-PC select codes and the bubble instruction.
package brq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        HOLD = 2'b11
    } ifu_state_e;

    localparam logic [1:0] NPC_PLUS4  = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JAL    = 2'b10;
    localparam logic [1:0] NPC_JALR   = 2'b11;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Jumps always redirect; a branch only redirects when its condition is taken.
    function automatic logic is_redirect(input logic [1:0] sel, input logic taken);
        return (sel == NPC_JAL) || (sel == NPC_JALR) || ((sel == NPC_BRANCH) && taken);
    endfunction

endpackage

// File: rtl/brq_ifu_skid.sv
// One-entry instruction/PC buffer. Holds a response that arrived while decode
// was stalled so the single outstanding memory request can still complete.
module brq_ifu_skid #(
    parameter int DataWidth = 32
) (
    input  logic                 brq_clk,
    input  logic                 brq_rst,
    input  logic                 load,
    input  logic                 clear,
    input  logic                 drain,
    input  logic [DataWidth-1:0] load_inst,
    input  logic [DataWidth-1:0] load_pc,
    output logic                 valid,
    output logic [DataWidth-1:0] inst,
    output logic [DataWidth-1:0] pc
);
    import brq_pkg::*;

    logic                 valid_q, valid_d;
    logic [DataWidth-1:0] inst_q, inst_d;
    logic [DataWidth-1:0] pc_q, pc_d;

    // Load wins over clear/drain; clear and drain both simply empty the entry.
    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        if (clear || drain) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            inst_d  = load_inst;
            pc_d    = load_pc;
        end
    end

    // Entry storage with synchronous reset to an empty, NOP-filled slot.
    always_ff @(posedge brq_clk) begin
        if (brq_rst) begin
            valid_q <= 1'b0;
            inst_q  <= DataWidth'(NOP_INST);
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign inst  = inst_q;
    assign pc    = pc_q;

endmodule

// File: rtl/brq_ifu.sv
// Buraq-mini instruction fetch unit. Keeps the fetch PC, issues one instruction
// memory request at a time, feeds decode with instructions or NOP bubbles, and
// follows decode redirects while respecting decode hazard holds.
// Optional feature: define BRQ_IFU_PERF_EN to add the ifu_fetch_count counter port.
module brq_ifu #(
    parameter int                   DataWidth = 32,
    parameter logic [DataWidth-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [DataWidth-1:0] NOP_INST  = 32'h0000_0013
) (
    input  logic                 brq_clk,
    input  logic                 brq_rst,
    input  logic [1:0]           idu_next_pc_sel,
    input  logic                 idu_branch,
    input  logic [DataWidth-1:0] idu_branch_addr,
    input  logic [DataWidth-1:0] idu_jal_addr,
    input  logic [DataWidth-1:0] idu_jalr_addr,
    input  logic [1:0]           idu_check_stall,
    output logic                 imem_req,
    output logic [DataWidth-1:0] imem_addr,
    input  logic                 imem_rvalid,
    input  logic [DataWidth-1:0] imem_rdata,
    output logic [DataWidth-1:0] ifu_fetch_inst,
    output logic [DataWidth-1:0] ifu_pc,
    output logic                 ifu_stall
`ifdef BRQ_IFU_PERF_EN
    ,
    output logic [31:0]          ifu_fetch_count
`endif
);
    import brq_pkg::*;

    ifu_state_e           state_q, state_d;
    logic [DataWidth-1:0] fetch_pc_q, fetch_pc_d;
    logic                 kill_q, kill_d;
    logic                 imem_req_q, imem_req_d;
    logic [DataWidth-1:0] imem_addr_q, imem_addr_d;
    logic [DataWidth-1:0] fetch_inst_q, fetch_inst_d;
    logic [DataWidth-1:0] ifu_pc_q, ifu_pc_d;
    logic                 ifu_stall_q, ifu_stall_d;

    logic                 hold;
    logic                 take_redirect;
    logic [DataWidth-1:0] target;

    logic                 accept;
    logic [DataWidth-1:0] accept_inst;
    logic [DataWidth-1:0] accept_pc;

    logic                 skid_load;
    logic                 skid_clear;
    logic                 skid_drain;
    logic                 skid_valid;
    logic [DataWidth-1:0] skid_inst;
    logic [DataWidth-1:0] skid_pc;

    brq_ifu_skid #(
        .DataWidth (DataWidth)
    ) u_skid (
        .brq_clk   (brq_clk),
        .brq_rst   (brq_rst),
        .load      (skid_load),
        .clear     (skid_clear),
        .drain     (skid_drain),
        .load_inst (imem_rdata),
        .load_pc   (fetch_pc_q),
        .valid     (skid_valid),
        .inst      (skid_inst),
        .pc        (skid_pc)
    );

    // Decode control: a hold masks any redirect because decode operands are not yet valid.
    always_comb begin
        hold = |idu_check_stall;
        case (idu_next_pc_sel)
            NPC_JAL:  target = idu_jal_addr;
            NPC_JALR: target = idu_jalr_addr;
            default:  target = idu_branch_addr;
        endcase
        take_redirect = is_redirect(idu_next_pc_sel, idu_branch) && !hold;
    end

    // Fetch FSM next state, fetch PC, kill tracking and next values of all registered outputs.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        kill_d       = kill_q;
        fetch_inst_d = fetch_inst_q;
        ifu_pc_d     = ifu_pc_q;
        ifu_stall_d  = ifu_stall_q;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;
        skid_drain   = 1'b0;
        accept       = 1'b0;
        accept_inst  = imem_rdata;
        accept_pc    = fetch_pc_q;

        case (state_q)
            IDLE: begin
                if (!hold) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                state_d = WAIT;
                if (take_redirect) begin
                    kill_d = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (kill_q || take_redirect) begin
                        kill_d  = 1'b0;
                        state_d = hold ? IDLE : REQ;
                    end else if (hold) begin
                        skid_load = 1'b1;
                        state_d   = HOLD;
                    end else begin
                        accept  = 1'b1;
                        state_d = REQ;
                    end
                end else if (take_redirect) begin
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                if (take_redirect) begin
                    skid_clear = 1'b1;
                    state_d    = REQ;
                end else if (!hold) begin
                    skid_drain  = 1'b1;
                    accept      = skid_valid;
                    accept_inst = skid_inst;
                    accept_pc   = skid_pc;
                    state_d     = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (take_redirect) begin
            fetch_pc_d   = target;
            fetch_inst_d = NOP_INST;
            ifu_stall_d  = 1'b1;
        end else if (accept) begin
            fetch_inst_d = accept_inst;
            ifu_pc_d     = accept_pc;
            ifu_stall_d  = 1'b0;
            fetch_pc_d   = fetch_pc_q + DataWidth'(4);
        end else if (!hold) begin
            fetch_inst_d = NOP_INST;
            ifu_stall_d  = 1'b1;
        end

        imem_req_d  = (state_d == REQ);
        imem_addr_d = (state_d == REQ) ? fetch_pc_d : imem_addr_q;
    end

    // Fetch FSM and all registered outputs, synchronous reset.
    always_ff @(posedge brq_clk) begin
        if (brq_rst) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            kill_q       <= 1'b0;
            imem_req_q   <= 1'b0;
            imem_addr_q  <= RESET_PC;
            fetch_inst_q <= NOP_INST;
            ifu_pc_q     <= RESET_PC;
            ifu_stall_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            kill_q       <= kill_d;
            imem_req_q   <= imem_req_d;
            imem_addr_q  <= imem_addr_d;
            fetch_inst_q <= fetch_inst_d;
            ifu_pc_q     <= ifu_pc_d;
            ifu_stall_q  <= ifu_stall_d;
        end
    end

    assign imem_req       = imem_req_q;
    assign imem_addr      = imem_addr_q;
    assign ifu_fetch_inst = fetch_inst_q;
    assign ifu_pc         = ifu_pc_q;
    assign ifu_stall      = ifu_stall_q;

`ifdef BRQ_IFU_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    // Count instructions handed to decode; discards and bubbles do not count.
    always_comb begin
        fetch_count_d = fetch_count_q + (accept ? 32'd1 : 32'd0);
    end

    // Counter register, wraps naturally at 2^32.
    always_ff @(posedge brq_clk) begin
        if (brq_rst) begin
            fetch_count_q <= 32'd0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign ifu_fetch_count = fetch_count_q;
`endif

endmodule

// File: doc/brq_ifu.md
# brq_ifu

Instruction fetch unit for the Buraq-mini 5-stage core. Holds the architectural fetch PC and issues one word request at a time to instruction memory over a valid/response handshake. Presents each fetched instruction and its PC to the decode stage, and inserts NOP bubbles when no instruction is available. Applies control-flow redirects computed in decode (branch, jal, jalr) and holds in place on decode hazard stalls.

## Interface
Parameters:
- DataWidth, 32, data/address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
- brq_clk  in  1  clock; sole clock domain
- brq_rst  in  1  reset; synchronous, active-high
- idu_next_pc_sel  in  2  next-PC select from decode: 00 = pc+4, 01 = branch, 10 = jal, 11 = jalr
- idu_branch  in  1  branch condition taken (only meaningful when sel = 01)
- idu_branch_addr  in  DataWidth  branch target
- idu_jal_addr  in  DataWidth  jal target
- idu_jalr_addr  in  DataWidth  jalr target, LSB already cleared
- idu_check_stall  in  2  decode hazard request; non-zero = hold
- imem_req  out  1  request valid, one cycle per request
- imem_addr  out  DataWidth  word-aligned request address
- imem_rvalid  in  1  response valid
- imem_rdata  in  DataWidth  response instruction
- ifu_fetch_inst  out  DataWidth  instruction to decode
- ifu_pc  out  DataWidth  PC of ifu_fetch_inst
- ifu_stall  out  1  1 = ifu_fetch_inst is a bubble
- ifu_fetch_count  out  32  retired-fetch counter (present only with BRQ_IFU_PERF_EN)

## Operation
- redirect = (sel == 10) | (sel == 11) | (sel == 01 & idu_branch). target = jal / jalr / branch address, selected by sel.
- hold = (idu_check_stall != 0). While hold is high, redirect is ignored, because decode operands are not yet valid.
- At most one request is outstanding. Memory latency is 1 or more cycles.
- FSM:
  - IDLE: after reset. Next cycle go to REQ.
  - REQ: drive imem_req = 1, imem_addr = fetch_pc. Go to WAIT.
  - WAIT: on imem_rvalid, either discard (if kill is set), capture into the skid buffer (if hold), or accept.
    - Accept: ifu_fetch_inst <= rdata, ifu_pc <= fetch_pc, ifu_stall <= 0, fetch_pc <= fetch_pc + 4. Go to REQ.
    - Discard: go to REQ with fetch_pc unchanged. fetch_pc was already loaded with the target at redirect time.
    - Capture: go to HOLD.
  - HOLD: skid entry valid. When hold drops, accept the skid entry exactly as above and go to REQ.
- Redirect in any state: fetch_pc <= target; ifu_fetch_inst <= NOP_INST; ifu_stall <= 1.
  - If in WAIT with no rvalid this cycle, set kill.
  - If in HOLD, invalidate the skid entry and go to REQ.
  - kill clears when the killed response returns.
- In REQ/WAIT with no accept and no hold, outputs become a bubble: NOP_INST, ifu_stall = 1. ifu_pc keeps its last value.
- While hold is high, ifu_fetch_inst, ifu_pc and ifu_stall are frozen. No new request is issued.
- PC arithmetic is modulo 2^DataWidth. 32'hFFFF_FFFC + 4 wraps to 0.
- Reset values: imem_req 0, imem_addr RESET_PC, ifu_fetch_inst NOP_INST, ifu_pc RESET_PC, ifu_stall 1, fetch_pc RESET_PC, kill 0, skid invalid, ifu_fetch_count 0.
- Reset mid-transaction: any in-flight response is ignored. Exactly one response may still arrive while in IDLE; it is dropped.

## Timing
- Reset deasserted at cycle 0 → IDLE at 0 → imem_req at cycle 1.
- With 1-cycle memory: one request every 2 cycles (REQ, WAIT). Instruction visible to decode the cycle after rvalid.
- Redirect at cycle t: bubble presented at t+1; target request issued no earlier than t+1 (REQ state) or after the killed response.
- imem_req, imem_addr, ifu_* are all registered. No combinational path from idu_* to imem_*.

## Configuration
- BRQ_IFU_PERF_EN defined: ifu_fetch_count increments by 1 on every accept (not on discard or bubble), wrapping at 2^32.
- BRQ_IFU_PERF_EN undefined: port and counter are absent.

## Structure
- Shared package brq_pkg: state enum ifu_state_e {IDLE, REQ, WAIT, HOLD}, next-PC select localparams (NPC_PLUS4/BRANCH/JAL/JALR), NOP_INST constant.
- One sub-module, brq_ifu_skid: one-entry instruction/PC buffer with valid, load, clear and drain.

## Test plan
- Reset then 1-cycle memory returning 0x00500093 at 0x0 → imem_req at cycle 1; ifu_fetch_inst = 0x00500093, ifu_pc = 0x0, ifu_stall = 0 at cycle 3; next imem_addr = 0x4.
- jal redirect (sel = 10, idu_jal_addr = 0x100) while in WAIT → bubble with ifu_stall = 1; response for the old address discarded; next imem_addr = 0x100.
- sel = 01 with idu_branch = 0 → no redirect; sequential fetch continues at pc+4.
- idu_check_stall = 01 asserted while a response arrives (rdata 0xDEADBEEF, addr 0x8) → outputs frozen; when hold drops, ifu_fetch_inst = 0xDEADBEEF, ifu_pc = 0x8.
- Hold and jalr redirect (0x200) in the same cycle → redirect ignored, fetch_pc unchanged.
- fetch_pc = 0xFFFFFFFC accepted → next imem_addr = 0x0. Reset asserted in WAIT → all outputs return to reset values; late rvalid dropped.
